// File: rtl/usb_pkg.sv
// Constants shared by the USB bit stuffer and unstuffer.
package usb_pkg;

  localparam int USB_STUFF_RUN_LEN = 6;
  localparam int USB_STRIP_CNT_W   = 8;

endpackage

// File: rtl/usb_bit_unstuffer.sv
// USB receive bit unstuffer: drops the 0 inserted after each run of RUN_LEN ones,
// flags stuffing violations and counts stripped bits per packet.
import usb_pkg::*;

module usb_bit_unstuffer #(
  parameter int RUN_LEN = USB_STUFF_RUN_LEN
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       pkt_active,
  input  logic       en,
  input  logic       in_bit,
  output logic       out_bit,
  output logic       out_valid,
  output logic       stuff_err,
  output logic [7:0] strip_cnt
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] ONES_MAX = CNT_W'(RUN_LEN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPECT_ZERO,
    ERROR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] ones_cnt, ones_n, ones_inc;
  logic             out_bit_n, out_valid_n, stuff_err_n;
  logic [7:0]       strip_cnt_n;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign ones_inc = ones_cnt + CNT_W'(1);

  always_comb begin
    state_n     = state;
    ones_n      = ones_cnt;
    out_bit_n   = 1'b0;
    out_valid_n = 1'b0;
    stuff_err_n = stuff_err;
    strip_cnt_n = strip_cnt;

    // Dropping pkt_active wins over any bit presented in the same cycle.
    if (!pkt_active) begin
      state_n     = IDLE;
      ones_n      = '0;
      stuff_err_n = 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (state == IDLE) begin
            strip_cnt_n = '0;
            stuff_err_n = 1'b0;
          end
          state_n = RUN;
          if (en) begin
            out_valid_n = 1'b1;
            out_bit_n   = in_bit;
            if (in_bit) begin
              ones_n = ones_inc;
              if (ones_inc == ONES_MAX) state_n = EXPECT_ZERO;
            end else begin
              ones_n = '0;
            end
          end
        end
        EXPECT_ZERO: begin
          if (en) begin
            if (in_bit) begin
              stuff_err_n = 1'b1;
              state_n     = ERROR;
            end else begin
              ones_n      = '0;
              strip_cnt_n = sat_inc(strip_cnt);
              state_n     = RUN;
            end
          end
        end
        ERROR: begin
          stuff_err_n = 1'b1;
        end
        default: begin
          state_n = IDLE;
          ones_n  = '0;
        end
      endcase
    end
  end

  // Output/state register stage
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      ones_cnt  <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      stuff_err <= 1'b0;
      strip_cnt <= '0;
    end else begin
      state     <= state_n;
      ones_cnt  <= ones_n;
      out_bit   <= out_bit_n;
      out_valid <= out_valid_n;
      stuff_err <= stuff_err_n;
      strip_cnt <= strip_cnt_n;
    end
  end

endmodule

// File: tb/tb_usb_bit_unstuffer.sv
// Directed bench for usb_bit_unstuffer with hand-computed expectations.
module tb_usb_bit_unstuffer;

  logic       clk = 1'b0;
  logic       nRST;
  logic       pkt_active;
  logic       en;
  logic       in_bit;
  logic       out_bit;
  logic       out_valid;
  logic       stuff_err;
  logic [7:0] strip_cnt;

  int checks = 0;
  int errors = 0;

  usb_bit_unstuffer #(.RUN_LEN(6)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .pkt_active (pkt_active),
    .en         (en),
    .in_bit     (in_bit),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .stuff_err  (stuff_err),
    .strip_cnt  (strip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic a, input logic e, input logic b);
    pkt_active = a;
    en         = e;
    in_bit     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic a, input logic e, input logic b,
                      input logic ev, input logic eb, input string tag);
    tick(a, e, b);
    chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, "_bit"},   32'(out_bit),   32'(eb));
  endtask

  initial begin
    nRST = 1'b0; pkt_active = 1'b0; en = 1'b0; in_bit = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bit",   32'(out_bit),   32'd0);
    chk("rst_err",   32'(stuff_err), 32'd0);
    chk("rst_strip", 32'(strip_cnt), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    nRST = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // 1111110 then 1: seven valid ones, stuffed zero removed
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t1_one");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t1_stuff");
    chk("t1_strip_after_drop", 32'(strip_cnt), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t1_seventh");
    chk("t1_strip", 32'(strip_cnt), 32'd1);
    chk("t1_err",   32'(stuff_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t1_gap");
    chk("t1_strip_hold", 32'(strip_cnt), 32'd1);

    // 1111111: six valid, then error latched and output silenced
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t2_one");
      chk("t2_err_early", 32'(stuff_err), 32'd0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "t2_bad");
    chk("t2_err", 32'(stuff_err), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t2_err_zero");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "t2_err_one");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t2_err_noen");
    chk("t2_err_hold", 32'(stuff_err), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t2_gap");
    chk("t2_err_clear", 32'(stuff_err), 32'd0);

    // en toggling: gaps give no output, stuffed 0 still dropped
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t3_one");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t3_gap");
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t3_stuff");
    chk("t3_strip", 32'(strip_cnt), 32'd1);
    chk("t3_err",   32'(stuff_err), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t3_data_zero");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t3_end");

    // 300 stuffed runs: strip_cnt saturates at 255
    for (int r = 1; r <= 300; r++) begin
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      chk("t4_strip", 32'(strip_cnt), (r > 255) ? 32'd255 : 32'(r));
    end
    chk("t4_err", 32'(stuff_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_end");
    chk("t4_strip_hold", 32'(strip_cnt), 32'd255);

    // 111111 then packet drop with en high; new packet starts with 0
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t5_first");
    chk("t5_strip_clear", 32'(strip_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t5_one");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t5_drop");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t5_new_zero");
    chk("t5_strip", 32'(strip_cnt), 32'd0);
    // five ones, drop, then two ones must both pass (counter restarted)
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t5b_one");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5b_drop");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t5b_next1");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t5b_next2");
    chk("t5b_err", 32'(stuff_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5b_end");

    // asynchronous reset after five ones
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t6_one");
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_bit",   32'(out_bit),   32'd0);
    chk("t6_rst_err",   32'(stuff_err), 32'd0);
    chk("t6_rst_strip", 32'(strip_cnt), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    nRST = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_idle");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "t6_fresh_one");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_stuff");
    chk("t6_strip", 32'(strip_cnt), 32'd1);
    chk("t6_err",   32'(stuff_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_bit_unstuffer.md
USB_BIT_UNSTUFFER -- requirements
Module: usb_bit_unstuffer

Interface
REQ-001 The block SHALL have parameter RUN_LEN, default USB_STUFF_RUN_LEN (6), meaning the number of consecutive 1s after which a stuffed 0 is expected.
REQ-002 The block SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-003 The block SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port pkt_active, input, 1, high from the first bit after SYNC up to EOP.
REQ-005 The block SHALL have port en, input, 1, in_bit valid this cycle.
REQ-006 The block SHALL have port in_bit, input, 1, NRZI-decoded receive bit.
REQ-007 The block SHALL have port out_bit, output, 1, unstuffed data bit.
REQ-008 The block SHALL have port out_valid, output, 1, out_bit valid this cycle.
REQ-009 The block SHALL have port stuff_err, output, 1, sticky bit-stuff violation flag for the current packet.
REQ-010 The block SHALL have port strip_cnt, output, 8, count of stuffed bits removed in the current or last packet.

Function
REQ-011 A bit SHALL be accepted only when en=1 and pkt_active=1; otherwise in_bit is ignored.
REQ-012 All outputs SHALL be registered; an accepted bit affects outputs exactly 1 cycle later.
REQ-013 The FSM SHALL have states IDLE, RUN, EXPECT_ZERO, ERROR.
REQ-014 In any state, pkt_active=0 SHALL force next state IDLE, clear the ones counter, and clear stuff_err.
REQ-015 IDLE with pkt_active=1 SHALL clear strip_cnt to 0 and process any accepted bit in the same cycle as RUN does.
REQ-016 IDLE/RUN, accepted bit: out_valid=1, out_bit=in_bit next cycle; ones counter increments on 1 and clears on 0.
REQ-017 IDLE/RUN: when an accepted 1 brings the ones counter to RUN_LEN, that bit SHALL still be output and the next state SHALL be EXPECT_ZERO.
REQ-018 EXPECT_ZERO, accepted 0: the bit SHALL be dropped (out_valid=0 next cycle), the counter cleared, strip_cnt incremented, and the next state SHALL be RUN.
REQ-019 EXPECT_ZERO, accepted 1: the bit SHALL be dropped, stuff_err SHALL be set next cycle, and the next state SHALL be ERROR.
REQ-020 EXPECT_ZERO with no accepted bit SHALL hold state.
REQ-021 ERROR SHALL hold stuff_err=1 and out_valid=0 regardless of en until pkt_active=0.
REQ-022 strip_cnt SHALL saturate at 255 with no wrap, and SHALL hold its value after pkt_active falls until the next IDLE->active entry.
REQ-023 The ones counter SHALL be $clog2(RUN_LEN+1) bits wide and SHALL never exceed RUN_LEN.
REQ-024 out_valid SHALL be 0 in any cycle following a cycle with no accepted bit; out_bit SHALL be 0 whenever out_valid=0.
REQ-025 If pkt_active falls in the same cycle en=1, the bit SHALL be ignored and the block SHALL go to IDLE.

Reset
REQ-026 nRST=0 SHALL asynchronously set state=IDLE, ones counter=0, out_bit=0, out_valid=0, stuff_err=0, strip_cnt=0.
REQ-027 Reset asserted mid-packet SHALL discard all in-flight state; after release the block SHALL wait in IDLE.

Structure
REQ-028 USB_STUFF_RUN_LEN SHALL live in the shared usb_pkg and be used by both the stuffer and this unstuffer; the FSM state typedef stays local to the module.
REQ-029 The block SHALL be a single module with no sub-modules.

Verification
REQ-030 The bench SHALL apply pkt_active=1, en=1, bits 1111110 then 1 and check that out_bit shows 1111111 (7 valids, stuffed 0 absent), strip_cnt=1, and stuff_err=0.
REQ-031 The bench SHALL apply bits 1111111 and check 6 valids, stuff_err=1 one cycle after the 7th bit, and no out_valid afterwards until pkt_active=0.
REQ-032 The bench SHALL apply bits 111111 with en toggling 1,0,1,... then 0 and check 6 outputs, the 0 dropped, and strip_cnt=1.
REQ-033 The bench SHALL run 300 repetitions of 1111110 in one packet and check strip_cnt saturates at 255.
REQ-034 The bench SHALL drop pkt_active after bits 111111, then start a new packet with 0 and check the 0 is output, the counter cleared, and strip_cnt=0.
REQ-035 The bench SHALL assert nRST mid-run after 5 ones and check all outputs are 0 immediately; after release, 1111110 SHALL be processed as a fresh run.
